// File: rtl/fetch_redirect_pkg.sv
// Shared core definitions for the fetch/redirect unit: data width, default
// reset vector and the fetch FSM state type.
package fetch_redirect_pkg;

    localparam int unsigned CORE_XLEN = 32;
    localparam logic [CORE_XLEN-1:0] CORE_RESET_PC = '0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_if.sv
// Fetch-side bundle: redirect inputs from EX, decode stall, instruction memory
// handshake and the IF/ID outputs. slave = fetch unit, master = its environment.
interface fetch_redirect_if
    import fetch_redirect_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
) ();

    logic            bj_valid;
    logic            pc_sel;
    logic [XLEN-1:0] target;
    logic            stall;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            instr_valid;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;
    logic            flush;

    modport slave (
        input  bj_valid, pc_sel, target, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc, flush
    );

    modport master (
        output bj_valid, pc_sel, target, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, flush
    );

endinterface

// File: rtl/fetch_redirect.sv
// Instruction fetch sequencer: issues one outstanding request at a time and
// squashes in-flight fetches when EX redirects the PC.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter int unsigned     XLEN     = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(CORE_RESET_PC)
) (
    input logic             i_clk,
    input logic             i_rst_n,
    fetch_redirect_if.slave bus
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    fetch_state_e    w_resume;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] r_pc_pend;
    logic [XLEN-1:0] w_pc_pend_nxt;
    logic [XLEN-1:0] r_instr_out;
    logic [XLEN-1:0] w_instr_out_nxt;
    logic [XLEN-1:0] r_instr_pc;
    logic [XLEN-1:0] w_instr_pc_nxt;
    logic            r_instr_valid;
    logic            w_instr_valid_nxt;
    logic            r_flush;
    logic            r_boot;
    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc_inc;

    assign w_redirect = bus.bj_valid & bus.pc_sel;
    assign w_target   = {bus.target[XLEN-1:2], 2'b00};
    assign w_pc_inc   = r_pc + XLEN'(4);
    // Once the current request completes, a stall parks the FSM instead of issuing.
    assign w_resume   = bus.stall ? StIdle : StFetch;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pc_pend_nxt     = r_pc_pend;
        w_instr_valid_nxt = 1'b0;
        w_instr_out_nxt   = r_instr_out;
        w_instr_pc_nxt    = r_instr_pc;

        unique case (r_state)
            StIdle: begin
                // r_boot delays the first issue by one cycle after reset release.
                if (w_redirect) begin
                    w_pc_nxt = w_target;
                end else if (r_boot && !bus.stall) begin
                    w_state_nxt = StFetch;
                end
            end
            StFetch: begin
                if (bus.imem_ack) begin
                    w_state_nxt = w_resume;
                    if (w_redirect) begin
                        w_pc_nxt = w_target;
                    end else begin
                        w_instr_valid_nxt = 1'b1;
                        w_instr_out_nxt   = bus.imem_rdata;
                        w_instr_pc_nxt    = r_pc;
                        w_pc_nxt          = w_pc_inc;
                    end
                end else if (w_redirect) begin
                    w_pc_pend_nxt = w_target;
                    w_state_nxt   = StDrain;
                end
            end
            StDrain: begin
                if (w_redirect) begin
                    w_pc_pend_nxt = w_target;
                end
                if (bus.imem_ack) begin
                    w_pc_nxt    = w_redirect ? w_target : r_pc_pend;
                    w_state_nxt = w_resume;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_pc_pend     <= '0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_flush       <= 1'b0;
            r_boot        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pc_pend     <= w_pc_pend_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_instr_out   <= w_instr_out_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_flush       <= w_redirect;
            r_boot        <= 1'b1;
        end
    end

    assign bus.imem_req    = (r_state != StIdle);
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.flush       = r_flush;

endmodule

// File: tb/tb_fetch_redirect.sv
// Self-checking bench for fetch_redirect: directed scenarios plus randomized
// traffic compared cycle by cycle against a behavioural fetch model.
module tb_fetch_redirect;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    fetch_redirect_if #(.XLEN(32)) bus_if ();

    fetch_redirect #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: busy = a request is on the bus, stale = it was superseded.
    bit          m_busy, m_stale, m_boot, m_valid, m_flush;
    logic [31:0] m_pc, m_pend, m_out, m_ipc;

    task automatic model_step(input bit bj, input bit sel, input bit ack, input bit stl,
                              input logic [31:0] tgt_raw, input logic [31:0] rdata);
        bit          redir;
        logic [31:0] tgt;
        redir   = bj & sel;
        tgt     = tgt_raw & 32'hFFFF_FFFC;
        m_flush = redir;
        m_valid = 1'b0;
        if (!m_busy) begin
            if (redir) m_pc = tgt;
            else if (m_boot && !stl) m_busy = 1'b1;
        end else if (m_stale) begin
            if (redir) m_pend = tgt;
            if (ack) begin
                m_pc    = m_pend;
                m_stale = 1'b0;
                m_busy  = !stl;
            end
        end else if (ack) begin
            if (redir) begin
                m_pc = tgt;
            end else begin
                m_valid = 1'b1;
                m_out   = rdata;
                m_ipc   = m_pc;
                m_pc    = m_pc + 32'd4;
            end
            m_busy = !stl;
        end else if (redir) begin
            m_stale = 1'b1;
            m_pend  = tgt;
        end
        m_boot = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.bj_valid   = 1'b0;
        bus_if.pc_sel     = 1'b0;
        bus_if.target     = '0;
        bus_if.stall      = 1'b0;
        bus_if.imem_ack   = 1'b0;
        bus_if.imem_rdata = '0;
    endtask

    task automatic redirect(input logic [31:0] t);
        bus_if.bj_valid = 1'b1;
        bus_if.pc_sel   = 1'b1;
        bus_if.target   = t;
    endtask

    // Leaves the DUT in FETCH at RESET_PC, two edges after release.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        clear_inputs();
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        do_reset();
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'hA5A5_1234;
        cyc();
        bus_if.imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.instr_out,
             bus_if.instr_pc, bus_if.flush} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0})
            $display("FAIL reset_async: req=%b addr=%h v=%b out=%h pc=%h fl=%b want all zero",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid,
                     bus_if.instr_out, bus_if.instr_pc, bus_if.flush);
        else n_pass++;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_checks++;
        if (bus_if.imem_req !== 1'b0)
            $display("FAIL reset_first_edge_req: got %b want 0", bus_if.imem_req);
        else n_pass++;
        cyc();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0})
            $display("FAIL reset_first_fetch: req=%b addr=%h want 1 00000000",
                     bus_if.imem_req, bus_if.imem_addr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] data, exp_pc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            exp_pc = 32'(k * 4);
            cyc();
            n_checks++;
            if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, exp_pc})
                $display("FAIL seq_req_%0d: req=%b addr=%h want 1 %h", k,
                         bus_if.imem_req, bus_if.imem_addr, exp_pc);
            else n_pass++;
            data              = $urandom;
            bus_if.imem_ack   = 1'b1;
            bus_if.imem_rdata = data;
            cyc();
            bus_if.imem_ack = 1'b0;
            n_checks++;
            if ({bus_if.instr_valid, bus_if.instr_out, bus_if.instr_pc, bus_if.flush}
                !== {1'b1, data, exp_pc, 1'b0})
                $display("FAIL seq_data_%0d: v=%b out=%h pc=%h fl=%b want 1 %h %h 0", k,
                         bus_if.instr_valid, bus_if.instr_out, bus_if.instr_pc,
                         bus_if.flush, data, exp_pc);
            else n_pass++;
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        bus_if.imem_ack = 1'b1;
        cyc();
        cyc();
        bus_if.imem_ack = 1'b0;
        redirect(32'h0000_0103);
        cyc();
        clear_inputs();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.flush, bus_if.instr_valid}
            !== {1'b1, 32'h8, 1'b1, 1'b0})
            $display("FAIL drain_enter: req=%b addr=%h fl=%b v=%b want 1 00000008 1 0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.flush, bus_if.instr_valid);
        else n_pass++;
        cyc();
        n_checks++;
        if ({bus_if.imem_addr, bus_if.flush} !== {32'h8, 1'b0})
            $display("FAIL drain_hold: addr=%h fl=%b want 00000008 0",
                     bus_if.imem_addr, bus_if.flush);
        else n_pass++;
        cyc();
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'hDEAD_BEEF;
        cyc();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush}
            !== {1'b1, 32'h100, 1'b0, 1'b0})
            $display("FAIL drain_exit: req=%b addr=%h v=%b fl=%b want 1 00000100 0 0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush);
        else n_pass++;
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'h1111_2222;
        cyc();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.instr_valid, bus_if.instr_pc, bus_if.instr_out}
            !== {1'b1, 32'h100, 32'h1111_2222})
            $display("FAIL drain_target_data: v=%b pc=%h out=%h want 1 00000100 11112222",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.instr_out);
        else n_pass++;
    endtask

    task automatic test_redirect_on_ack();
        do_reset();
        bus_if.imem_ack = 1'b1;
        cyc();
        redirect(32'h0000_0200);
        bus_if.imem_rdata = 32'h0BAD_0BAD;
        cyc();
        clear_inputs();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush}
            !== {1'b1, 32'h200, 1'b0, 1'b1})
            $display("FAIL ack_redirect: req=%b addr=%h v=%b fl=%b want 1 00000200 0 1",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush);
        else n_pass++;
        cyc();
        n_checks++;
        if ({bus_if.flush, bus_if.imem_addr} !== {1'b0, 32'h200})
            $display("FAIL ack_redirect_after: fl=%b addr=%h want 0 00000200",
                     bus_if.flush, bus_if.imem_addr);
        else n_pass++;
    endtask

    task automatic test_double_redirect();
        do_reset();
        bus_if.bj_valid = 1'b1;
        bus_if.target   = 32'h0000_0700;
        cyc();
        n_checks++;
        if ({bus_if.imem_addr, bus_if.flush, bus_if.imem_req} !== {32'h0, 1'b0, 1'b1})
            $display("FAIL not_taken_ignored: addr=%h fl=%b req=%b want 00000000 0 1",
                     bus_if.imem_addr, bus_if.flush, bus_if.imem_req);
        else n_pass++;
        redirect(32'h0000_0300);
        cyc();
        n_checks++;
        if (bus_if.flush !== 1'b1) $display("FAIL dbl_flush1: got %b want 1", bus_if.flush);
        else n_pass++;
        redirect(32'h0000_0400);
        cyc();
        clear_inputs();
        n_checks++;
        if ({bus_if.flush, bus_if.imem_addr} !== {1'b1, 32'h0})
            $display("FAIL dbl_flush2: fl=%b addr=%h want 1 00000000",
                     bus_if.flush, bus_if.imem_addr);
        else n_pass++;
        cyc();
        bus_if.imem_ack = 1'b1;
        cyc();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush}
            !== {1'b1, 32'h400, 1'b0, 1'b0})
            $display("FAIL dbl_last_wins: req=%b addr=%h v=%b fl=%b want 1 00000400 0 0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush);
        else n_pass++;
    endtask

    task automatic test_wrap_stall();
        do_reset();
        bus_if.imem_ack = 1'b1;
        redirect(32'hFFFF_FFFF);
        cyc();
        clear_inputs();
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'h1234_5678;
        cyc();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.instr_valid, bus_if.instr_pc, bus_if.imem_addr, bus_if.imem_req}
            !== {1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1})
            $display("FAIL wrap: v=%b pc=%h addr=%h req=%b want 1 fffffffc 00000000 1",
                     bus_if.instr_valid, bus_if.instr_pc, bus_if.imem_addr, bus_if.imem_req);
        else n_pass++;
        bus_if.imem_ack   = 1'b1;
        bus_if.stall      = 1'b1;
        bus_if.imem_rdata = 32'h9ABC_DEF0;
        cyc();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.instr_pc}
            !== {1'b0, 32'h4, 1'b1, 32'h0})
            $display("FAIL stall_at_ack: req=%b addr=%h v=%b pc=%h want 0 00000004 1 00000000",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.instr_pc);
        else n_pass++;
        cyc();
        n_checks++;
        if (bus_if.imem_req !== 1'b0)
            $display("FAIL stall_hold: req=%b want 0", bus_if.imem_req);
        else n_pass++;
        bus_if.stall = 1'b0;
        cyc();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h4})
            $display("FAIL stall_resume: req=%b addr=%h want 1 00000004",
                     bus_if.imem_req, bus_if.imem_addr);
        else n_pass++;
        bus_if.imem_ack = 1'b1;
        bus_if.stall    = 1'b1;
        cyc();
        bus_if.imem_ack = 1'b0;
        redirect(32'h0000_0502);
        cyc();
        bus_if.bj_valid = 1'b0;
        bus_if.pc_sel   = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.flush} !== {1'b0, 32'h500, 1'b1})
            $display("FAIL stall_redirect: req=%b addr=%h fl=%b want 0 00000500 1",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.flush);
        else n_pass++;
        clear_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        redirect(32'h0000_0600);
        cyc();
        clear_inputs();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush}
            !== {1'b0, 32'h0, 1'b0, 1'b0})
            $display("FAIL drain_reset: req=%b addr=%h v=%b fl=%b want 0 00000000 0 0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush);
        else n_pass++;
        cyc();
        bus_if.imem_ack   = 1'b1;
        bus_if.imem_rdata = 32'h5555_AAAA;
        rst_n             = 1'b1;
        cyc();
        bus_if.imem_ack = 1'b0;
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid} !== {1'b0, 32'h0, 1'b0})
            $display("FAIL late_ack_ignored: req=%b addr=%h v=%b want 0 00000000 0",
                     bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid);
        else n_pass++;
        cyc();
        n_checks++;
        if ({bus_if.imem_req, bus_if.imem_addr} !== {1'b1, 32'h0})
            $display("FAIL drain_reset_refetch: req=%b addr=%h want 1 00000000",
                     bus_if.imem_req, bus_if.imem_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          bj, sel, ack, stl;
        logic [31:0] tgt, rdata;
        do_reset();
        m_busy  = 1'b1;
        m_stale = 1'b0;
        m_boot  = 1'b1;
        m_pc    = 32'h0;
        m_pend  = 32'h0;
        m_valid = 1'b0;
        m_flush = 1'b0;
        m_out   = 32'h0;
        m_ipc   = 32'h0;
        for (int i = 0; i < 400; i++) begin
            n_checks++;
            if ({bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid, bus_if.flush,
                 bus_if.instr_out, bus_if.instr_pc}
                !== {m_busy, m_pc, m_valid, m_flush, m_out, m_ipc})
                $display("FAIL random_cycle_%0d: req=%b addr=%h v=%b fl=%b out=%h pc=%h want req=%b addr=%h v=%b fl=%b out=%h pc=%h",
                         i, bus_if.imem_req, bus_if.imem_addr, bus_if.instr_valid,
                         bus_if.flush, bus_if.instr_out, bus_if.instr_pc,
                         m_busy, m_pc, m_valid, m_flush, m_out, m_ipc);
            else n_pass++;
            bj    = ($urandom_range(0, 4) == 0);
            sel   = ($urandom_range(0, 1) == 0);
            ack   = ($urandom_range(0, 9) < 4);
            stl   = ($urandom_range(0, 3) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                                : $urandom_range(0, 1023);
            rdata = $urandom;
            bus_if.bj_valid   = bj;
            bus_if.pc_sel     = sel;
            bus_if.imem_ack   = ack;
            bus_if.stall      = stl;
            bus_if.target     = tgt;
            bus_if.imem_rdata = rdata;
            model_step(bj, sel, ack, stl, tgt, rdata);
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_redirect_drain();
        test_redirect_on_ack();
        test_double_redirect();
        test_wrap_stall();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fetch_redirect.md
FETCH_REDIRECT -- requirements
Module: fetch_redirect

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter XLEN, 32, address/instruction width.
REQ-003 CLK  in  1  single clock, all state on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 BJ_VALID  in  1  EX stage holds a resolved branch/jump this cycle.
REQ-006 PC_SEL  in  1  branch/jump taken (from the branch/jump detector), qualified by BJ_VALID.
REQ-007 TARGET  in  XLEN  redirect address from EX.
REQ-008 STALL  in  1  decode not accepting; block new fetch issue.
REQ-009 IMEM_ACK  in  1  instruction memory returns IMEM_RDATA for the outstanding request.
REQ-010 IMEM_RDATA  in  XLEN  fetched instruction word.
REQ-011 IMEM_REQ  out  1  fetch request outstanding.
REQ-012 IMEM_ADDR  out  XLEN  fetch address, word aligned.
REQ-013 INSTR_VALID  out  1  one-cycle pulse, INSTR_OUT/INSTR_PC valid.
REQ-014 INSTR_OUT  out  XLEN  registered fetched instruction.
REQ-015 INSTR_PC  out  XLEN  address of INSTR_OUT.
REQ-016 FLUSH  out  1  one-cycle pulse, the cycle after an accepted redirect; IF/ID drops its contents.

Function
REQ-017 States: IDLE (no request), FETCH (request outstanding, address valid), DRAIN (stale request outstanding, redirect pending).
REQ-018 IDLE -> FETCH when STALL=0; IMEM_REQ=1 from the cycle after the transition decision, IMEM_ADDR=PC.
REQ-019 FETCH: IMEM_REQ and IMEM_ADDR held stable until IMEM_ACK=1.
REQ-020 FETCH, IMEM_ACK=1, no redirect: next cycle INSTR_VALID=1, INSTR_OUT=IMEM_RDATA, INSTR_PC=old PC; PC <= PC+4 (mod 2^32, 0xFFFF_FFFC wraps to 0); stay FETCH if STALL=0 else go IDLE.
REQ-021 Redirect = BJ_VALID & PC_SEL; BJ_VALID with PC_SEL=0 has no effect.
REQ-022 Redirect target = {TARGET[XLEN-1:2], 2'b00}; low bits silently cleared.
REQ-023 Redirect in IDLE: PC <= target; state rules of REQ-018 apply next cycle.
REQ-024 Redirect in FETCH with IMEM_ACK=0: PC_PEND <= target, go DRAIN; IMEM_ADDR keeps old address.
REQ-025 Redirect in FETCH with IMEM_ACK=1: returned data discarded (INSTR_VALID=0), PC <= target, stay FETCH (or IDLE if STALL=1).
REQ-026 DRAIN: IMEM_ACK data discarded; on IMEM_ACK, PC <= PC_PEND, go FETCH (IDLE if STALL=1).
REQ-027 Redirect in DRAIN overwrites PC_PEND (last redirect wins); redirect coincident with ACK in DRAIN uses the new target.
REQ-028 Every accepted redirect asserts FLUSH exactly one cycle later; back-to-back redirects give back-to-back FLUSH.
REQ-029 STALL never blocks a redirect or an in-flight request; it only prevents issuing a new one.
REQ-030 INSTR_VALID never asserts for data fetched from a superseded address.

Reset
REQ-031 RESET_N=0 asynchronously forces: state IDLE, PC=RESET_PC, PC_PEND=0, IMEM_REQ=0, IMEM_ADDR=RESET_PC, INSTR_VALID=0, INSTR_OUT=0, INSTR_PC=0, FLUSH=0.
REQ-032 Reset during FETCH/DRAIN abandons the outstanding request; a late IMEM_ACK after release while in IDLE is ignored.
REQ-033 First request issues no earlier than the second rising CLK edge after RESET_N deasserts.

Structure
REQ-034 State enum (IDLE, FETCH, DRAIN), XLEN and default RESET_PC live in the shared core package.
REQ-035 Single module, no sub-modules; PC, PC_PEND, output registers and state register in one sequential block with asynchronous reset.

Verification
REQ-036 Reset release, STALL=0, ACK one cycle after each request -> IMEM_ADDR 0x0,0x4,0x8; INSTR_PC matches; no FLUSH.
REQ-037 Redirect TARGET=0x103 while FETCH at 0x8, ACK 3 cycles later -> DRAIN, 0x8 data dropped, FLUSH one pulse, next IMEM_ADDR=0x100.
REQ-038 Redirect to 0x200 coincident with ACK at 0x4 -> no INSTR_VALID, next IMEM_ADDR=0x200, FLUSH next cycle.
REQ-039 Two redirects (0x300, then 0x400) during DRAIN -> next IMEM_ADDR=0x400, two FLUSH pulses.
REQ-040 PC=0xFFFF_FFFC ACK -> next IMEM_ADDR=0x0; STALL=1 at ACK -> IMEM_REQ low, resumes at next address when STALL=0.
REQ-041 RESET_N low mid-DRAIN, ACK after release -> outputs at reset values, ACK ignored, first fetch at RESET_PC.
